// File: rtl/stream_downsizer.sv
// Valid/ready width converter: holds one wide word from an upstream FIFO and emits it
// as 1..Ratio narrow beats, least-significant slice first, with zero-bubble reload.
module stream_downsizer #(
  parameter int InWidth  = 64,
  parameter int OutWidth = 16,
  localparam int Ratio   = InWidth / OutWidth,
  localparam int CntW    = $clog2(Ratio)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_vld_i,
  input  logic [InWidth-1:0]  in_payload_i,
  input  logic [CntW-1:0]     in_len_i,
  output logic                in_rdy_o,
  output logic                out_vld_o,
  output logic [OutWidth-1:0] out_payload_o,
  output logic                out_last_o,
  input  logic                out_rdy_i,
  input  logic                flush_i,
  output logic                busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                           state, state_next;
  logic [CntW-1:0]                  idx, idx_next;
  logic [CntW-1:0]                  len, len_next;
  logic [InWidth-1:0]               hold, hold_next;
  logic [Ratio-1:0][OutWidth-1:0]   slices;
  logic                             in_fire, out_fire;

  assign slices        = hold;
  assign out_vld_o     = (state == SEND);
  assign busy_o        = out_vld_o;
  assign out_last_o    = out_vld_o && (idx == len);
  assign out_payload_o = out_vld_o ? slices[idx] : '0;

  // Ready looks through to out_rdy_i so a new word loads in the cycle the last beat leaves.
  assign in_rdy_o = !flush_i && ((state == IDLE) || (out_last_o && out_rdy_i));
  assign in_fire  = in_vld_i && in_rdy_o;
  assign out_fire = out_vld_o && out_rdy_i;

  // NOTE: every next-state signal gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    len_next   = len;
    hold_next  = hold;
    if (flush_i) begin
      state_next = IDLE;
      idx_next   = '0;
    end else if (in_fire) begin
      state_next = SEND;
      idx_next   = '0;
      len_next   = in_len_i;
      hold_next  = in_payload_i;
    end else if (out_fire) begin
      if (out_last_o) begin
        state_next = IDLE;
        idx_next   = '0;
      end else begin
        idx_next = idx + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from the values sampled at the edge.
  // NOTE: the hold register is reset too, so out_payload_o is defined from reset
  // onward without relying on the IDLE mux alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      idx   <= '0;
      len   <= '0;
      hold  <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      len   <= len_next;
      hold  <= hold_next;
    end
  end

endmodule

// File: tb/tb_stream_downsizer.sv
// Self-checking bench for stream_downsizer: directed scenarios plus randomized traffic
// checked against a queue-of-beats reference model.
module tb_stream_downsizer;

  localparam int InWidth  = 64;
  localparam int OutWidth = 16;
  localparam int Ratio    = InWidth / OutWidth;
  localparam int CntW     = $clog2(Ratio);

  logic                clk = 1'b0;
  logic                rstn;
  logic                in_vld;
  logic [InWidth-1:0]  in_payload;
  logic [CntW-1:0]     in_len;
  logic                in_rdy;
  logic                out_vld;
  logic [OutWidth-1:0] out_payload;
  logic                out_last;
  logic                out_rdy;
  logic                flush;
  logic                busy;

  stream_downsizer #(.InWidth(InWidth), .OutWidth(OutWidth)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_vld_i     (in_vld),
    .in_payload_i (in_payload),
    .in_len_i     (in_len),
    .in_rdy_o     (in_rdy),
    .out_vld_o    (out_vld),
    .out_payload_o(out_payload),
    .out_last_o   (out_last),
    .out_rdy_i    (out_rdy),
    .flush_i      (flush),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OutWidth-1:0] data;
    logic                last;
  } beat_t;

  // Beats still owed to the consumer, in delivery order.
  beat_t q[$];
  int    n_vec    = 0;
  int    n_err    = 0;
  int    accepted = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [InWidth-1:0] w, input logic [CntW-1:0] l);
    beat_t b;
    for (int i = 0; i <= int'(l); i++) begin
      b.data = w[i*OutWidth +: OutWidth];
      b.last = (i == int'(l));
      q.push_back(b);
    end
    accepted++;
  endtask

  // One clock cycle: drive at the falling edge, check shortly after, advance the model.
  task automatic cycle(input logic v, input logic [InWidth-1:0] w, input logic [CntW-1:0] l,
                       input logic r, input logic f);
    logic exp_rdy;
    @(negedge clk);
    in_vld = v; in_payload = w; in_len = l; out_rdy = r; flush = f;
    #1;
    exp_rdy = !f && ((q.size() == 0) || (q.size() == 1 && r));
    check("in_rdy", in_rdy, exp_rdy);
    check("out_vld", out_vld, q.size() != 0);
    check("busy", busy, q.size() != 0);
    if (q.size() != 0) begin
      check("payload", out_payload, q[0].data);
      check("last", out_last, q[0].last);
    end else begin
      check("idle_payload", out_payload, '0);
      check("idle_last", out_last, 1'b0);
    end
    if (r && q.size() != 0) void'(q.pop_front());
    if (f) q.delete();
    else if (v && exp_rdy) push_word(w, l);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    int cyc;
    rstn = 1'b0; in_vld = 1'b0; in_payload = '0; in_len = '0; out_rdy = 1'b0; flush = 1'b0;
    #12;
    check("rst_out_vld", out_vld, 1'b0);
    check("rst_payload", out_payload, '0);
    check("rst_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_rdy", in_rdy, 1'b1);
    @(negedge clk);
    rstn = 1'b1;

    // Single full-length word, then two back-to-back words with no bubble.
    cycle(1'b1, 64'h4444_3333_2222_1111, 2'd3, 1'b1, 1'b0);
    idle_cycles(4);
    cycle(1'b1, 64'h4444_3333_2222_1111, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b1, 64'hDDDD_CCCC_BBBB_AAAA, 2'd3, 1'b1, 1'b0);
    idle_cycles(5);

    // Short lengths.
    cycle(1'b1, 64'h4444_3333_2222_1111, 2'd0, 1'b1, 1'b0);
    idle_cycles(2);
    cycle(1'b1, 64'h4444_3333_2222_1111, 2'd1, 1'b1, 1'b0);
    idle_cycles(3);

    // Flush on the second beat while a new word is offered.
    cycle(1'b1, 64'h4444_3333_2222_1111, 2'd3, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b1, 64'h9999_8888_7777_6666, 2'd3, 1'b1, 1'b1);
    cycle(1'b1, 64'h9999_8888_7777_6666, 2'd3, 1'b1, 1'b0);
    idle_cycles(5);

    // Asynchronous reset mid-word.
    cycle(1'b1, 64'h4444_3333_2222_1111, 2'd3, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("arst_out_vld", out_vld, 1'b0);
    check("arst_payload", out_payload, '0);
    check("arst_busy", busy, 1'b0);
    check("arst_last", out_last, 1'b0);
    q.delete();
    @(negedge clk);
    rstn = 1'b1;
    cycle(1'b1, 64'h5555_AAAA_F0F0_0F0F, 2'd3, 1'b1, 1'b0);
    idle_cycles(5);

    // Randomized traffic with backpressure and occasional flush.
    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      cycle(($urandom % 4) != 0, {$urandom, $urandom}, CntW'($urandom_range(0, Ratio - 1)),
            ($urandom % 2) != 0, ($urandom % 50) == 0);
      cyc++;
    end
    check("word_budget", accepted >= 1000, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check("drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
